// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - Moore control FSM for the multicycle RV32I datapath
//
// Purpose: sequences each instruction through Fetch/Decode/Execute/Memory/
// Writeback and drives the ALU operation class, datapath mux selects and write
// enables. Outputs are registered and depend only on the current state.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   reset      in   1  asynchronous active-high reset, forces Fetch
//   op         in   7  instr[6:0], sampled in Decode and MemAdr
//   ALUOp      out  2  00 add, 01 subtract, 10 decode funct fields
//   ALUSrcA    out  2  00 PC, 01 OldPC, 10 rs1 data
//   ALUSrcB    out  2  00 rs2 data, 01 ImmExt, 10 constant 4
//   ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
//   AdrSrc     out  1  memory address: 0 PC, 1 Result
//   IRWrite    out  1  load IR and OldPC
//   PCUpdate   out  1  unconditional PC write
//   Branch     out  1  conditional PC write (gated with Zero outside)
//   RegWrite   out  1  register file write enable
//   MemWrite   out  1  data memory write enable
//   state      out  4  current state code
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECUTER  = 4'd6,
    S_ALUWB     = 4'd7,
    S_EXECUTEI  = 4'd8,
    S_JAL       = 4'd9,
    S_BEQ       = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  // Codes 11-15 and unsupported opcodes all fall back to Fetch.
  function automatic logic [3:0] next_of(input logic [3:0] s, input logic [6:0] o);
    logic [3:0] n;
    n = S_FETCH;
    case (s)
      S_FETCH:    n = S_DECODE;
      S_DECODE: begin
        case (o)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_R:         n = S_EXECUTER;
          OP_I:         n = S_EXECUTEI;
          OP_JAL:       n = S_JAL;
          OP_BEQ:       n = S_BEQ;
          default:      n = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (o == OP_LW)      n = S_MEMREAD;
        else if (o == OP_SW) n = S_MEMWRITE;
        else                 n = S_FETCH;
      end
      S_MEMREAD:  n = S_MEMWB;
      S_MEMWB:    n = S_FETCH;
      S_MEMWRITE: n = S_FETCH;
      S_EXECUTER: n = S_ALUWB;
      S_EXECUTEI: n = S_ALUWB;
      S_ALUWB:    n = S_FETCH;
      S_JAL:      n = S_ALUWB;
      S_BEQ:      n = S_FETCH;
      default:    n = S_FETCH;
    endcase
    return n;
  endfunction

  // Control word for a state, packed as
  // {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite}.
  // Anything not set stays 0 so no output is ever X.
  function automatic logic [13:0] ctl_of(input logic [3:0] s);
    logic [1:0] alu_op, src_a, src_b, res_src;
    logic       adr_src, ir_wr, pc_upd, br, reg_wr, mem_wr;
    alu_op  = 2'b00;
    src_a   = 2'b00;
    src_b   = 2'b00;
    res_src = 2'b00;
    adr_src = 1'b0;
    ir_wr   = 1'b0;
    pc_upd  = 1'b0;
    br      = 1'b0;
    reg_wr  = 1'b0;
    mem_wr  = 1'b0;
    case (s)
      S_FETCH: begin
        ir_wr = 1'b1; src_b = 2'b10; res_src = 2'b10; pc_upd = 1'b1;
      end
      S_DECODE: begin
        src_a = 2'b01; src_b = 2'b01;
      end
      S_MEMADR: begin
        src_a = 2'b10; src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        res_src = 2'b01; reg_wr = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1; mem_wr = 1'b1;
      end
      S_EXECUTER: begin
        src_a = 2'b10; src_b = 2'b00; alu_op = 2'b10;
      end
      S_EXECUTEI: begin
        src_a = 2'b10; src_b = 2'b01; alu_op = 2'b10;
      end
      S_ALUWB: begin
        reg_wr = 1'b1;
      end
      S_JAL: begin
        src_a = 2'b01; src_b = 2'b10; pc_upd = 1'b1;
      end
      S_BEQ: begin
        src_a = 2'b10; src_b = 2'b00; alu_op = 2'b01; br = 1'b1;
      end
      default: begin
        alu_op = 2'b00;
      end
    endcase
    return {alu_op, src_a, src_b, res_src, adr_src, ir_wr, pc_upd, br, reg_wr, mem_wr};
  endfunction

  // Outputs are loaded from the decode of the state being entered, so they
  // always match the state register without a combinational output path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite,
       PCUpdate, Branch, RegWrite, MemWrite} <= ctl_of(S_FETCH);
    end else begin
      state <= next_of(state, op);
      {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite,
       PCUpdate, Branch, RegWrite, MemWrite} <= ctl_of(next_of(state, op));
    end
  end

endmodule

// File: tb/tb_main_fsm.sv
// tb/tb_main_fsm.sv - scoreboard bench for main_fsm with random instruction stream
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
  logic       AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite;
  logic [3:0] state;

  main_fsm dut (
    .clk(clk), .reset(reset), .op(op),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCUpdate(PCUpdate), .Branch(Branch),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] res_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
  } ctl_t;

  typedef struct {
    int   st;
    ctl_t ctl;
  } exp_t;

  exp_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Per-phase control values taken straight from the state descriptions.
  function automatic ctl_t ctl_for(int st);
    ctl_t c = '0;
    case (st)
      0:  begin c.ir_write = 1; c.src_b = 2; c.res_src = 2; c.pc_update = 1; end
      1:  begin c.src_a = 1; c.src_b = 1; end
      2:  begin c.src_a = 2; c.src_b = 1; end
      3:  begin c.adr_src = 1; end
      4:  begin c.res_src = 1; c.reg_write = 1; end
      5:  begin c.adr_src = 1; c.mem_write = 1; end
      6:  begin c.src_a = 2; c.alu_op = 2; end
      7:  begin c.reg_write = 1; end
      8:  begin c.src_a = 2; c.src_b = 1; c.alu_op = 2; end
      9:  begin c.src_a = 1; c.src_b = 2; c.pc_update = 1; end
      10: begin c.src_a = 2; c.alu_op = 1; c.branch = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Reference: the phase list an instruction walks through from its Fetch,
  // by instruction class. Pushes at most 'limit' phases; returns the count.
  function automatic int push_instr(logic [6:0] o, int limit);
    int   seq[$];
    exp_t e;
    case (o)
      7'b0000011: seq = {0, 1, 2, 3, 4};
      7'b0100011: seq = {0, 1, 2, 5};
      7'b0110011: seq = {0, 1, 6, 7};
      7'b0010011: seq = {0, 1, 8, 7};
      7'b1101111: seq = {0, 1, 9, 7};
      7'b1100011: seq = {0, 1, 10};
      default:    seq = {0, 1};
    endcase
    while (seq.size() > limit) void'(seq.pop_back());
    foreach (seq[k]) begin
      e.st  = seq[k];
      e.ctl = ctl_for(seq[k]);
      expq.push_back(e);
    end
    return seq.size();
  endfunction

  function automatic ctl_t ctl_now();
    return {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite,
            PCUpdate, Branch, RegWrite, MemWrite};
  endfunction

  // Direct check used by the reset and illegal-state scenarios.
  task automatic check_fetch(string name);
    vectors++;
    if (state != 4'd0 || ctl_now() != ctl_for(0)) begin
      miscompares++;
      $display("FAIL %s: state got %0d want 0, ctl got %b want %b",
               name, state, ctl_now(), ctl_for(0));
    end
  endtask

  // Monitor: every cycle with an outstanding expectation, pop and compare.
  initial begin : monitor
    exp_t e;
    ctl_t got;
    forever begin
      @(negedge clk);
      #1;
      if (expq.size() > 0) begin
        e   = expq.pop_front();
        got = ctl_now();
        vectors++;
        if (state != e.st[3:0] || got != e.ctl) begin
          miscompares++;
          $display("FAIL seq op=%b: state got %0d want %0d, ctl got %b want %b",
                   op, state, e.st, got, e.ctl);
        end
        vectors++;
        if ((32'(RegWrite) + 32'(MemWrite) + 32'(IRWrite)) > 1) begin
          miscompares++;
          $display("FAIL write_excl: state %0d RegWrite=%b MemWrite=%b IRWrite=%b",
                   state, RegWrite, MemWrite, IRWrite);
        end
      end
    end
  end

  logic [6:0] ops [8];
  int         lat;

  initial begin : driver
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b0010011; ops[4] = 7'b1101111; ops[5] = 7'b1100011;
    ops[6] = 7'b1110011; ops[7] = 7'b0000000;
    reset = 1'b1;
    op    = 7'b0;
    repeat (2) @(negedge clk);
    #1 check_fetch("reset_state");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 300; i++) begin
      if (i == 40) begin
        // Reset while lw sits in MemRead: no MemWB write may follow.
        op  = 7'b0000011;
        lat = push_instr(op, 4);
        repeat (lat - 1) @(negedge clk);
        #3 reset = 1'b1;
        #1 check_fetch("reset_midcycle");
        @(posedge clk);
        #1 check_fetch("reset_held");
        @(negedge clk);
        reset = 1'b0;
      end
      if (i == 80) begin
        // Illegal code 13 must go to Fetch, not to Decode.
        op = 7'b0110011;
        force dut.state = 4'd13;
        release dut.state;
        @(posedge clk);
        #1 check_fetch("illegal_state");
        @(negedge clk);
      end
      op = ops[$urandom_range(0, 7)];
      if (op == 7'b0000000) op = 7'($urandom);
      lat = push_instr(op, 99);
      repeat (lat) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
